// File: rtl/fullchip_pkg.sv
// Shared defaults and state encoding for the accelerator core datapath.
package fullchip_pkg;
  localparam int COL_DEF = 8;
  localparam int BW_DEF  = 8;

  typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} norm_state_t;

  // Normalized magnitudes carry one bit less than the signed output width.
  function automatic int frac_bits(input int w);
    return w - 1;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, DW cycles from start to done.
module seq_divider #(
  parameter int DW = 27,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);
  localparam int CW = $clog2(DW + 1);

  logic [SW-1:0] rem, dsr, rem_in, dsr_in, rem_nxt;
  logic [DW-1:0] shreg, sh_in;
  logic [SW:0]   trial;
  logic          fits;
  logic [CW-1:0] cnt;

  // The first step runs on the start edge straight from the operands.
  always_comb begin
    rem_in  = busy ? rem : '0;
    sh_in   = busy ? shreg : dividend;
    dsr_in  = busy ? dsr : divisor;
    trial   = {rem_in, sh_in[DW-1]};
    fits    = trial >= {1'b0, dsr_in};
    rem_nxt = fits ? SW'(trial - {1'b0, dsr_in}) : trial[SW-1:0];
  end

  assign quotient = shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      dsr   <= '0;
      shreg <= '0;
    end else begin
      done <= 1'b0;
      if (busy || start) begin
        rem   <= rem_nxt;
        shreg <= {sh_in[DW-2:0], fits};
        dsr   <= dsr_in;
      end
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        cnt  <= CW'(1);
        busy <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/psum_norm.sv
// Sign-preserving L1 normalization of one psum vector using a single shared divider.
module psum_norm
  import fullchip_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int bw      = BW_DEF,
  parameter int bw_psum = 2 * bw + 4,
  parameter int FRAC    = frac_bits(bw)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw_psum*col-1:0] in_psum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw*col-1:0]      out_data
);
  localparam int DW = bw_psum + FRAC;
  localparam int SW = bw_psum + $clog2(col);
  localparam int KW = (col > 1) ? $clog2(col) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(col - 1);

  norm_state_t state, state_nxt;

  logic signed [bw_psum-1:0] psum_p0 [col];
  logic [bw_psum-1:0]        abs_c   [col];
  logic [bw_psum-1:0]        abs_p1  [col];
  logic [SW-1:0]             sum_c, sum_p1;
  logic [KW-1:0]             k, k_inc;
  logic [bw*col-1:0]         work, work_nxt;
  logic [bw_psum-1:0]        abs_sel;
  logic                      div_start, div_busy, div_done;
  logic [DW-1:0]             div_dividend, div_quotient;
  logic [SW-1:0]             div_divisor;

  // Quotient >= 2^FRAC only happens when one element carries the whole sum.
  function automatic logic signed [bw-1:0] sat_sign(input logic [DW-1:0] quo,
                                                    input logic neg,
                                                    input logic zero_div);
    logic [FRAC-1:0]       mag;
    logic signed [bw-1:0]  m;
    if (zero_div)                 mag = '0;
    else if (quo[DW-1:FRAC] != '0) mag = '1;
    else                          mag = quo[FRAC-1:0];
    m = signed'({{(bw-FRAC){1'b0}}, mag});
    return neg ? -m : m;
  endfunction

  // Stage p0 -> p1: magnitudes and their sum
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < col; i++) begin
      abs_c[i] = psum_p0[i][bw_psum-1] ? unsigned'(-psum_p0[i]) : unsigned'(psum_p0[i]);
      sum_c    = sum_c + SW'(abs_c[i]);
    end
  end

  assign k_inc = k + 1'b1;

  // Element 0 starts on the SUM edge from the combinational sum; later ones chain on done.
  always_comb begin
    abs_sel      = (state == SUM) ? abs_c[0] : abs_p1[k_inc];
    div_dividend = {abs_sel, {FRAC{1'b0}}};
    div_divisor  = (state == SUM) ? sum_c : sum_p1;
    div_start    = !div_busy &&
                   ((state == SUM) || (state == DIV && div_done && k != K_LAST));
  end

  seq_divider #(.DW(DW), .SW(SW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    work_nxt[k*bw +: bw] = sat_sign(div_quotient, psum_p0[k][bw_psum-1], sum_p1 == '0);
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SUM;
      SUM:     state_nxt = DIV;
      DIV:     if (div_done && k == K_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == SUM) begin
        k <= '0;
      end else if (state == DIV && div_done) begin
        k <= k_inc;
        if (k == K_LAST) out_data <= work_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      for (int i = 0; i < col; i++) psum_p0[i] <= signed'(in_psum[i*bw_psum +: bw_psum]);
    end
    if (state == SUM) begin
      abs_p1 <= abs_c;
      sum_p1 <= sum_c;
    end
    if (state == DIV && div_done) work <= work_nxt;
  end
endmodule

// File: tb/tb_psum_norm.sv
// Bench for psum_norm: table vectors, backpressure, mid-run reset and random traffic.
module tb_psum_norm;
  localparam int COL = 8;
  localparam int BW  = 8;
  localparam int BWP = 20;
  localparam int PW  = BWP * COL;
  localparam int OW  = BW * COL;
  localparam int LAT = 217;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic man_ready, rnd_bit, rnd_ready;
  logic [PW-1:0] in_psum;
  logic [OW-1:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_edge = 0;
  logic ov_prev = 1'b0;
  logic [OW-1:0] exp_q[$];

  typedef struct {
    int p[COL];
    int q[COL];
  } vec_t;
  vec_t tbl[6];

  assign out_ready = rnd_ready ? rnd_bit : man_ready;

  psum_norm dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pack_p(input int p[COL]);
    logic [PW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      v = p[k];
      r[k*BWP +: BWP] = v[BWP-1:0];
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] pack_q(input int q[COL]);
    logic [OW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      v = q[k];
      r[k*BW +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] model(input logic [PW-1:0] p);
    longint a[COL];
    logic   neg[COL];
    longint s, m;
    logic signed [BWP-1:0] x;
    logic [OW-1:0] r;
    s = 0;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      x = p[k*BWP +: BWP];
      neg[k] = (x < 0);
      a[k] = neg[k] ? -longint'(x) : longint'(x);
      s += a[k];
    end
    for (int k = 0; k < COL; k++) begin
      m = (s == 0) ? 0 : (a[k] * 128) / s;
      if (m > 127) m = 127;
      if (neg[k]) m = -m;
      r[k*BW +: BW] = m[BW-1:0];
    end
    return r;
  endfunction

  // Output monitor: latency, exclusivity of ready/valid, and scoreboard compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_edge = cyc + 1;
      if (out_valid && !ov_prev) begin
        chk("latency", OW'(cyc - acc_edge), OW'(LAT));
        chk("ready_excl", OW'(in_ready), OW'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", OW'(1), OW'(0));
        else chk("out_data", out_data, exp_q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [PW-1:0] p, input logic [OW-1:0] e);
    int n;
    n = 0;
    in_psum  = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", OW'(0), OW'(1));
    else exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", OW'(exp_q.size()), OW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] snap;
    logic [PW-1:0] p;
    logic [19:0]   rv;
    int            sv, n;

    tbl[0].p = '{100, 100, 100, 100, 100, 100, 100, 100};
    tbl[0].q = '{16, 16, 16, 16, 16, 16, 16, 16};
    tbl[1].p = '{500, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].q = '{127, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].p = '{-300, 100, 0, 0, 0, 0, 0, 200};
    tbl[2].q = '{-64, 21, 0, 0, 0, 0, 0, 42};
    tbl[3].p = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].q = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4].p = '{-524288, 0, 0, 0, 0, 0, 0, 0};
    tbl[4].q = '{-127, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].p = '{-1, 1, 0, 0, 0, 0, 0, 0};
    tbl[5].q = '{-64, 64, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; in_valid = 1'b0; in_psum = '0;
    man_ready = 1'b1; rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_out_data", out_data, OW'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send(pack_p(tbl[i].p), pack_q(tbl[i].q));
      wait_drain();
    end

    // Backpressure: result held, offered vector refused until after the out handshake.
    man_ready = 1'b0;
    send(pack_p(tbl[2].p), pack_q(tbl[2].q));
    n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", OW'(out_valid), OW'(1));
    snap = out_data;
    in_psum  = pack_p(tbl[0].p);
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", out_data, snap);
      chk("bp_in_ready", OW'(in_ready), OW'(0));
    end
    @(posedge clk);
    #1 man_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_early_accept", OW'(in_ready), OW'(0));
    @(negedge clk);
    chk("bp_accept", OW'(in_ready), OW'(1));
    exp_q.push_back(pack_q(tbl[0].q));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of DIV aborts the vector.
    send(pack_p(tbl[1].p), pack_q(tbl[1].q));
    repeat (52) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", OW'(in_ready), OW'(1));
    chk("mid_rst_out_valid", OW'(out_valid), OW'(0));
    chk("mid_rst_out_data", out_data, OW'(0));
    @(posedge clk);
    #1;
    send(pack_p(tbl[2].p), pack_q(tbl[2].q));
    wait_drain();

    // Random psums with random input gaps and output stalls.
    rnd_ready = 1'b1;
    for (int v = 0; v < 20; v++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      p = '0;
      for (int k = 0; k < COL; k++) begin
        case ($urandom_range(0, 3))
          0: rv = '0;
          1: begin
            sv = int'($urandom_range(0, 2000)) - 1000;
            rv = sv[19:0];
          end
          2: rv = 20'($urandom);
          default: rv = $urandom_range(0, 1) ? 20'h80000 : 20'h7FFFF;
        endcase
        p[k*BWP +: BWP] = rv;
      end
      send(p, model(p));
    end
    wait_drain();
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
